cfg_strobe_receiver: RTL and testbench

//  On-chip end of the DATA/STB configuration port driven by the test driver. Decodes the strobed
//  two-phase write (STB rise = address/mode, STB fall = data) into per-channel register fields
//  (PCAP, ONESHOT, LOCKOUT, DAC) and a test-point address. Sits between the pad ring and the

---
 rtl/cfg_strobe_if.sv | 47 ++++
 rtl/cfg_strobe_receiver.sv | 169 ++++++++++++++++
 tb/tb_cfg_strobe_receiver.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_strobe_if.sv
// DATA/STB configuration port between the test driver and the receiver.
// The rdata readback bus exists only when CFG_READBACK_EN is defined.
interface cfg_strobe_if #(
    parameter int CHANNELS = 16,
    parameter int DATABITS = 8
);
    logic [DATABITS-1:0]   data;
    logic                  stb;
    logic                  gen;
    logic [4*CHANNELS-1:0] prog_cap;
    logic [2*CHANNELS-1:0] tp_mux;
    logic [CHANNELS-1:0]   nowlin;
    logic [3*CHANNELS-1:0] trim;
    logic [CHANNELS-1:0]   lockout_mode;
    logic [2*CHANNELS-1:0] os_width;
    logic [5*CHANNELS-1:0] lockout_cv;
    logic [CHANNELS-1:0]   lockout_en_l;
    logic [6*CHANNELS-1:0] le_dac;
    logic [CHANNELS-1:0]   chan_en;
    logic [3:0]            tp_addr;
    logic                  cfg_err;
`ifdef CFG_READBACK_EN
    logic [DATABITS-1:0]   rdata;

    modport master (
        output data, stb, gen,
        input  prog_cap, tp_mux, nowlin, trim, lockout_mode, os_width,
               lockout_cv, lockout_en_l, le_dac, chan_en, tp_addr, cfg_err, rdata
    );
    modport slave (
        input  data, stb, gen,
        output prog_cap, tp_mux, nowlin, trim, lockout_mode, os_width,
               lockout_cv, lockout_en_l, le_dac, chan_en, tp_addr, cfg_err, rdata
    );
`else
    modport master (
        output data, stb, gen,
        input  prog_cap, tp_mux, nowlin, trim, lockout_mode, os_width,
               lockout_cv, lockout_en_l, le_dac, chan_en, tp_addr, cfg_err
    );
    modport slave (
        input  data, stb, gen,
        output prog_cap, tp_mux, nowlin, trim, lockout_mode, os_width,
               lockout_cv, lockout_en_l, le_dac, chan_en, tp_addr, cfg_err
    );
`endif
endinterface

// File: rtl/cfg_strobe_receiver.sv
// Decodes the two-phase DATA/STB config write into per-channel register fields.
// Define CFG_READBACK_EN to add the rdata readback of the addressed register.
module cfg_strobe_receiver #(
    parameter int CHANNELS = 16,
    parameter int DATABITS = 8,
    parameter int SYNC_ST  = 2
) (
    input  logic        clk,
    input  logic        rst_l,
    cfg_strobe_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADDR, COMMIT} state_t;

    localparam logic [2:0] MODE_TP      = 3'd0;
    localparam logic [2:0] MODE_PCAP    = 3'd1;
    localparam logic [2:0] MODE_ONESHOT = 3'd2;
    localparam logic [2:0] MODE_LOCKOUT = 3'd3;
    localparam logic [2:0] MODE_DAC     = 3'd4;

    state_t                       state;
    logic [SYNC_ST-1:0]           stb_sync_p0;
    logic                         stb_p1;
    logic                         rise_det, fall_det;
    logic [3:0]                   addr_q;
    logic                         gmode_q;
    logic [2:0]                   mode_q;
    logic [DATABITS-2:0]          wdata_q;
    logic                         mode_valid, addr_valid, commit_ok, commit_err;
    logic [CHANNELS-1:0]          wr_sel;

    logic [CHANNELS-1:0][3:0]     prog_cap_q;
    logic [CHANNELS-1:0][1:0]     tp_mux_q;
    logic [CHANNELS-1:0]          nowlin_q;
    logic [CHANNELS-1:0][2:0]     trim_q;
    logic [CHANNELS-1:0]          lockout_mode_q;
    logic [CHANNELS-1:0][1:0]     os_width_q;
    logic [CHANNELS-1:0][4:0]     lockout_cv_q;
    logic [CHANNELS-1:0]          lockout_en_l_q;
    logic [CHANNELS-1:0][5:0]     le_dac_q;
    logic [CHANNELS-1:0]          chan_en_q;
    logic [3:0]                   tp_addr_q;
    logic                         cfg_err_q;

    // Synchronizer and edge detector stay unreset: an STB held high across
    // reset must not look like a fresh rise once reset is released.
    always_ff @(posedge clk) begin
        stb_sync_p0 <= {stb_sync_p0[SYNC_ST-2:0], bus.stb};
        stb_p1      <= stb_sync_p0[SYNC_ST-1];
    end

    assign rise_det = stb_sync_p0[SYNC_ST-1] & ~stb_p1;
    assign fall_det = ~stb_sync_p0[SYNC_ST-1] & stb_p1;

    always_ff @(posedge clk) begin
        if (state == IDLE && rise_det) begin
            addr_q  <= bus.data[7:4];
            gmode_q <= bus.data[3];
            mode_q  <= bus.data[2:0];
        end
        if (state == ADDR && fall_det) begin
            wdata_q <= bus.data[DATABITS-2:0];
        end
    end

    always_comb begin
        mode_valid = (mode_q >= MODE_PCAP) && (mode_q <= MODE_DAC);
        addr_valid = gmode_q || (int'(addr_q) < CHANNELS);
        commit_ok  = (state == COMMIT) && !bus.gen && mode_valid && addr_valid;
        commit_err = (state == COMMIT) && (mode_q != MODE_TP) && !commit_ok;
        wr_sel     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_sel[i] = commit_ok && (gmode_q || int'(addr_q) == i);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state          <= IDLE;
            tp_addr_q      <= '0;
            cfg_err_q      <= 1'b0;
            prog_cap_q     <= '0;
            tp_mux_q       <= '0;
            nowlin_q       <= '0;
            trim_q         <= {CHANNELS{3'h4}};
            lockout_mode_q <= '0;
            os_width_q     <= '0;
            lockout_cv_q   <= '0;
            lockout_en_l_q <= '1;
            le_dac_q       <= {CHANNELS{6'h3F}};
            chan_en_q      <= '0;
        end else begin
            cfg_err_q <= commit_err;
            case (state)
                IDLE:    if (rise_det) state <= ADDR;
                ADDR: begin
                    // Test-point routing follows the address phase alone, GEN is not consulted
                    if (mode_q == MODE_TP) tp_addr_q <= addr_q;
                    if (fall_det) state <= COMMIT;
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_sel[i]) begin
                    case (mode_q)
                        MODE_PCAP: begin
                            nowlin_q[i]   <= wdata_q[6];
                            tp_mux_q[i]   <= wdata_q[5:4];
                            prog_cap_q[i] <= wdata_q[3:0];
                        end
                        MODE_ONESHOT: begin
                            os_width_q[i]     <= wdata_q[5:4];
                            lockout_mode_q[i] <= wdata_q[3];
                            trim_q[i]         <= wdata_q[2:0];
                        end
                        MODE_LOCKOUT: begin
                            lockout_en_l_q[i] <= wdata_q[5];
                            lockout_cv_q[i]   <= wdata_q[4:0];
                        end
                        MODE_DAC: begin
                            chan_en_q[i] <= wdata_q[6];
                            le_dac_q[i]  <= wdata_q[5:0];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.prog_cap     = prog_cap_q;
    assign bus.tp_mux       = tp_mux_q;
    assign bus.nowlin       = nowlin_q;
    assign bus.trim         = trim_q;
    assign bus.lockout_mode = lockout_mode_q;
    assign bus.os_width     = os_width_q;
    assign bus.lockout_cv   = lockout_cv_q;
    assign bus.lockout_en_l = lockout_en_l_q;
    assign bus.le_dac       = le_dac_q;
    assign bus.chan_en      = chan_en_q;
    assign bus.tp_addr      = tp_addr_q;
    assign bus.cfg_err      = cfg_err_q;

`ifdef CFG_READBACK_EN
    logic [DATABITS-1:0] rb_word, rdata_q;

    always_comb begin
        rb_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ((gmode_q ? 0 : int'(addr_q)) == i) begin
                case (mode_q)
                    MODE_PCAP:    rb_word = {1'b0, nowlin_q[i], tp_mux_q[i], prog_cap_q[i]};
                    MODE_ONESHOT: rb_word = {2'b0, os_width_q[i], lockout_mode_q[i], trim_q[i]};
                    MODE_LOCKOUT: rb_word = {2'b0, lockout_en_l_q[i], lockout_cv_q[i]};
                    MODE_DAC:     rb_word = {1'b0, chan_en_q[i], le_dac_q[i]};
                    default:      rb_word = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rb_word;
    end

    // Gating on state blanks the stale word in COMMIT and keeps IDLE at zero
    assign bus.rdata = (state == ADDR) ? rdata_q : '0;
`endif
endmodule

// File: tb/tb_cfg_strobe_receiver.sv
// Bench for cfg_strobe_receiver: vector table, hand sequences and random
// transactions against a register-word model of the configuration space.
module tb_cfg_strobe_receiver;
    localparam int CH = 8;
    localparam int SS = 2;

    typedef struct {
        logic [7:0] aw;
        logic [7:0] dw;
        logic       g;
        int         exp_err;
        int         pmode;
        int         pch;
        logic [7:0] pword;
        logic [3:0] exp_tp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_l;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   err_cnt = 0;

    // model: one data-phase word per mode (1..4) per channel, plus TP_ADDR
    logic [7:0] m_reg [1:4][CH];
    logic [3:0] m_tp;

    always #5 clk = ~clk;

    cfg_strobe_if #(.CHANNELS(CH), .DATABITS(8)) bus ();

    cfg_strobe_receiver #(.CHANNELS(CH), .DATABITS(8), .SYNC_ST(SS)) dut (
        .clk  (clk),
        .rst_l(rst_l),
        .bus  (bus)
    );

    always @(negedge clk) if (bus.cfg_err === 1'b1) err_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] word_mask(input int m);
        return (m == 1 || m == 4) ? 8'h7F : 8'h3F;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_reg[1][c] = 8'h00;
            m_reg[2][c] = 8'h04;
            m_reg[3][c] = 8'h20;
            m_reg[4][c] = 8'h3F;
        end
        m_tp = 4'd0;
    endtask

    task automatic model_addr(input int aw);
        if (aw % 8 == 0) m_tp = 4'(aw / 16);
    endtask

    function automatic int model_commit(input int aw, input int dw, input int g);
        int mode = aw % 8;
        int gm   = (aw / 8) % 2;
        int a    = aw / 16;
        if (mode == 0) return 0;
        if (g != 0 || mode > 4 || (gm == 0 && a >= CH)) return 1;
        for (int c = 0; c < CH; c++)
            if (gm != 0 || c == a) m_reg[mode][c] = 8'(dw) & word_mask(mode);
        return 0;
    endfunction

    function automatic logic [7:0] get_word(input int m, input int c);
        case (m)
            1:       return {1'b0, bus.nowlin[c], bus.tp_mux[2*c +: 2], bus.prog_cap[4*c +: 4]};
            2:       return {2'b0, bus.os_width[2*c +: 2], bus.lockout_mode[c], bus.trim[3*c +: 3]};
            3:       return {2'b0, bus.lockout_en_l[c], bus.lockout_cv[5*c +: 5]};
            default: return {1'b0, bus.chan_en[c], bus.le_dac[6*c +: 6]};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [63:0] e_pc, e_tm, e_nw, e_tr, e_lm, e_os, e_cv, e_el, e_le, e_en;
        {e_pc, e_tm, e_nw, e_tr, e_lm} = '0;
        {e_os, e_cv, e_el, e_le, e_en} = '0;
        for (int c = 0; c < CH; c++) begin
            e_pc[4*c +: 4] = m_reg[1][c][3:0];
            e_tm[2*c +: 2] = m_reg[1][c][5:4];
            e_nw[c]        = m_reg[1][c][6];
            e_tr[3*c +: 3] = m_reg[2][c][2:0];
            e_lm[c]        = m_reg[2][c][3];
            e_os[2*c +: 2] = m_reg[2][c][5:4];
            e_cv[5*c +: 5] = m_reg[3][c][4:0];
            e_el[c]        = m_reg[3][c][5];
            e_le[6*c +: 6] = m_reg[4][c][5:0];
            e_en[c]        = m_reg[4][c][6];
        end
        chk({tag, ".prog_cap"},     64'(bus.prog_cap),     e_pc);
        chk({tag, ".tp_mux"},       64'(bus.tp_mux),       e_tm);
        chk({tag, ".nowlin"},       64'(bus.nowlin),       e_nw);
        chk({tag, ".trim"},         64'(bus.trim),         e_tr);
        chk({tag, ".lockout_mode"}, 64'(bus.lockout_mode), e_lm);
        chk({tag, ".os_width"},     64'(bus.os_width),     e_os);
        chk({tag, ".lockout_cv"},   64'(bus.lockout_cv),   e_cv);
        chk({tag, ".lockout_en_l"}, 64'(bus.lockout_en_l), e_el);
        chk({tag, ".le_dac"},       64'(bus.le_dac),       e_le);
        chk({tag, ".chan_en"},      64'(bus.chan_en),      e_en);
        chk({tag, ".tp_addr"},      64'(bus.tp_addr),      64'(m_tp));
    endtask

    // full write; outputs must hold for SS+1 cycles after the STB fall and change on the next
    task automatic xfer(input logic [7:0] aw, input logic [7:0] dw,
                        input logic g_addr, input logic g_com, output int exp_err);
        @(negedge clk);
        bus.gen  = g_addr;
        bus.data = aw;
        err_cnt  = 0;
        repeat (SS + 3) @(negedge clk);
        bus.stb = 1'b1;
        repeat (SS + 4) @(negedge clk);
        model_addr(int'(aw));
        bus.data = dw;
        bus.gen  = g_com;
        repeat (SS + 3) @(negedge clk);
        bus.stb = 1'b0;
        repeat (SS + 1) @(negedge clk);
        check_all($sformatf("pre_%02h", aw));
        exp_err = model_commit(int'(aw), int'(dw), int'(g_com));
        @(negedge clk);
        check_all($sformatf("post_%02h", aw));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vec_t tbl[10];
        int   e;

        tbl[0] = '{8'h09, 8'h41, 1'b0, 0, 1, 5, 8'h41, 4'd0};
        tbl[1] = '{8'h34, 8'h6F, 1'b0, 0, 4, 3, 8'h6F, 4'd0};
        tbl[2] = '{8'h0B, 8'h01, 1'b1, 1, 3, 0, 8'h20, 4'd0};
        tbl[3] = '{8'hF2, 8'h3F, 1'b0, 1, 2, 7, 8'h04, 4'd0};
        tbl[4] = '{8'h5A, 8'hFF, 1'b0, 0, 2, 1, 8'h3F, 4'd0};
        tbl[5] = '{8'h25, 8'h11, 1'b0, 1, 4, 2, 8'h3F, 4'd0};
        tbl[6] = '{8'h73, 8'h15, 1'b0, 0, 3, 7, 8'h15, 4'd0};
        tbl[7] = '{8'h50, 8'h00, 1'b1, 0, 1, 5, 8'h41, 4'd5};
        tbl[8] = '{8'h1C, 8'h80, 1'b0, 0, 4, 3, 8'h00, 4'd5};
        tbl[9] = '{8'h66, 8'h22, 1'b0, 1, 1, 6, 8'h41, 4'd5};

        rst_l    = 1'b0;
        bus.stb  = 1'b0;
        bus.data = 8'h00;
        bus.gen  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        repeat (20) @(negedge clk);
        check_all("reset");
        chk("reset.cfg_err", 64'(bus.cfg_err), 64'd0);
        chk("reset.trim4",   64'(bus.trim),   64'({CH{3'h4}}));
        chk("reset.le_dac3f", 64'(bus.le_dac), 64'({CH{6'h3F}}));
        chk("reset.en_l",    64'(bus.lockout_en_l), 64'({CH{1'b1}}));

        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i].aw, tbl[i].dw, tbl[i].g, tbl[i].g, e);
            chk($sformatf("vec%0d.cfg_err_pulses", i), 64'(err_cnt), 64'(tbl[i].exp_err));
            chk($sformatf("vec%0d.model_err", i), 64'(e), 64'(tbl[i].exp_err));
            chk($sformatf("vec%0d.probe", i), 64'(get_word(tbl[i].pmode, tbl[i].pch)), 64'(tbl[i].pword));
            chk($sformatf("vec%0d.tp_addr", i), 64'(bus.tp_addr), 64'(tbl[i].exp_tp));
        end

        // GEN high during the address phase only: the commit still goes through
        xfer(8'h11, 8'h4A, 1'b1, 1'b0, e);
        chk("gen_toggle.err", 64'(err_cnt), 64'd0);
        chk("gen_toggle.word", 64'(get_word(1, 1)), 64'h4A);
        xfer(8'h11, 8'h05, 1'b0, 1'b1, e);
        chk("gen_late.err", 64'(err_cnt), 64'd1);
        chk("gen_late.word", 64'(get_word(1, 1)), 64'h4A);

        // ch3 DAC write, then readback
        xfer(8'h34, 8'h6F, 1'b0, 1'b0, e);
        chk("ch3_dac.word", 64'(get_word(4, 3)), 64'h6F);
        chk("ch2_dac.word", 64'(get_word(4, 2)), 64'h00);
`ifdef CFG_READBACK_EN
        @(negedge clk);
        bus.data = 8'h34;
        bus.gen  = 1'b1;
        err_cnt  = 0;
        repeat (SS + 3) @(negedge clk);
        chk("rdata.idle", 64'(bus.rdata), 64'd0);
        bus.stb = 1'b1;
        repeat (SS + 4) @(negedge clk);
        chk("rdata.ch3_dac", 64'(bus.rdata), 64'h6F);
        bus.stb = 1'b0;
        repeat (SS + 6) @(negedge clk);
        e = model_commit(32'h34, 32'h34, 1);
        chk("rdata.after", 64'(bus.rdata), 64'd0);
        chk("rdata.err", 64'(err_cnt), 64'(e));
        check_all("rdata");
`endif

        // reset while in ADDR; the lone STB fall afterwards writes nothing
        @(negedge clk);
        bus.gen  = 1'b0;
        bus.data = 8'h14;
        err_cnt  = 0;
        repeat (SS + 3) @(negedge clk);
        bus.stb = 1'b1;
        repeat (SS + 4) @(negedge clk);
        rst_l = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        repeat (SS + 3) @(negedge clk);
        bus.data = 8'h55;
        repeat (SS + 3) @(negedge clk);
        bus.stb = 1'b0;
        repeat (SS + 8) @(negedge clk);
        check_all("mid_reset");
        chk("mid_reset.err", 64'(err_cnt), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] aw, dw;
            logic       ga, gc;
            aw = 8'($urandom_range(0, 255));
            dw = 8'($urandom);
            ga = 1'($urandom_range(0, 1));
            gc = ($urandom_range(0, 3) == 0);
            xfer(aw, dw, ga, gc, e);
            chk($sformatf("rnd%0d_%02h.err", i, aw), 64'(err_cnt), 64'(e));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
